// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon datapath blocks.
// Field is built on the primitive polynomial 0x11D, matching the log/inverse ROM.
// Also holds the exponentiation engine's state encoding.
package gf_pkg;
   localparam int         GF_W     = 8;
   localparam logic [8:0] GF_POLY  = 9'h11D;
   localparam logic [7:0] GF_ALPHA = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } pow_state_e;
endpackage

// File: rtl/gf_pow_engine_if.sv
// Request/response bundle for the GF(2^8) exponentiation engine.
// master = requester/consumer side, slave = engine side.
// Request is valid/ready; result is held valid until out_ready.
interface gf_pow_engine_if;
   import gf_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [GF_W-1:0] in_base;
   logic [GF_W-1:0] in_exp;
   logic            out_valid;
   logic            out_ready;
   logic [GF_W-1:0] out_data;
   logic            busy;

   modport master (
      output in_valid, in_base, in_exp, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_base, in_exp, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/gf_mul.sv
// Combinational 8x8 GF(2^8) multiplier, product reduced by POLY.
// Latency: zero cycles (pure combinational).
// Backpressure: none; no handshake.
module gf_mul
   import gf_pkg::*;
#(
   parameter logic [8:0] POLY = GF_POLY
) (
   input  logic [GF_W-1:0] a_i,
   input  logic [GF_W-1:0] b_i,
   output logic [GF_W-1:0] p_o
);

   logic [GF_W-1:0] prod;
   logic [GF_W-1:0] shifted;

   // Shift-and-add: walk b LSB-first, keeping a*x^i reduced as it is shifted.
   always_comb begin
      prod    = '0;
      shifted = a_i;
      for (int i = 0; i < GF_W; i++) begin
         if (b_i[i]) begin
            prod = prod ^ shifted;
         end
         shifted = {shifted[GF_W-2:0], 1'b0} ^ (shifted[GF_W-1] ? POLY[GF_W-1:0] : '0);
      end
   end

   assign p_o = prod;

endmodule

// File: rtl/gf_pow_engine.sv
// Computes base^exp in GF(2^8) by MSB-first square-and-multiply, one exponent bit per cycle.
// Latency: result valid 8 clocks after the accepting edge; one operation in flight.
// Backpressure: result held in DONE until out_ready; requests refused outside IDLE.
module gf_pow_engine
   import gf_pkg::*;
#(
   parameter logic [8:0] POLY = GF_POLY,
   parameter int         W    = GF_W
) (
   input  logic            clk,
   input  logic            rst,
   gf_pow_engine_if.slave  io
);

   pow_state_e state_q;
   logic [W-1:0] base_q;
   logic [W-1:0] exp_q;
   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;
   logic [W-1:0] sq;
   logic [W-1:0] mul_op;
   logic [2:0]   k_q;
   logic [W-1:0] out_data_q;
   logic         out_valid_q;
   logic         busy_q;

   // Square the running value, then fold in base when the current exponent bit is set.
   gf_mul #(.POLY(POLY)) u_sq (
      .a_i (acc_q),
      .b_i (acc_q),
      .p_o (sq)
   );

   assign mul_op = exp_q[k_q] ? base_q : {{(W-1){1'b0}}, 1'b1};

   gf_mul #(.POLY(POLY)) u_mul (
      .a_i (sq),
      .b_i (mul_op),
      .p_o (acc_d)
   );

   // Control FSM: latch request, run exactly 8 bit-steps, hold result until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         exp_q       <= '0;
         acc_q       <= {{(W-1){1'b0}}, 1'b1};
         k_q         <= 3'd7;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (io.in_valid && io.in_ready) begin
                  base_q  <= io.in_base;
                  exp_q   <= io.in_exp;
                  acc_q   <= {{(W-1){1'b0}}, 1'b1};
                  k_q     <= 3'd7;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_q <= acc_d;
               k_q   <= k_q - 3'd1;
               if (k_q == 3'd0) begin
                  out_data_q  <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (io.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   // Ready depends only on registered state, never on in_valid.
   assign io.in_ready  = (state_q == ST_IDLE);
   assign io.out_valid = out_valid_q;
   assign io.out_data  = out_data_q;
   assign io.busy      = busy_q;

endmodule

// File: tb/tb_gf_pow_engine.sv
// Self-checking bench for gf_pow_engine: fixed vectors, sweeps, random ops
// against a repeated-multiplication reference, plus backpressure and reset sequences.
module tb_gf_pow_engine;
   import gf_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   gf_pow_engine_if bus ();

   gf_pow_engine dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      logic [7:0] e;
      logic [7:0] r;
   } vec_t;

   // Reference: carry-less product reduced by 0x11D, powers by repeated multiplication.
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      logic [15:0] poly;
      p    = 16'h0;
      poly = 16'h011D;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ (16'(a) << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (poly << (i - 8));
      end
      return p[7:0];
   endfunction

   function automatic logic [7:0] m_pow(input logic [7:0] b, input logic [7:0] e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < int'(e); i++) r = m_mul(r, b);
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the handshake edge.
   task automatic run_op(input logic [7:0] b, input logic [7:0] e,
                         output logic [7:0] res, output int lat, output bit ir_low);
      bus.in_valid  = 1'b1;
      bus.in_base   = b;
      bus.in_exp    = e;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_base  = 8'($urandom);
      bus.in_exp   = 8'($urandom);
      lat    = 0;
      ir_low = !bus.in_ready;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus.in_ready) ir_low = 1'b0;
      end
      res = bus.out_data;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   vec_t       vecs[10];
   logic [7:0] res;
   int         lat;
   bit         ir_low;
   int         logt[256];
   logic [7:0] v;
   logic [7:0] rb;
   logic [7:0] re;
   bit         stable;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      vecs[0] = '{8'd2,   8'd1,   8'd2};
      vecs[1] = '{8'd2,   8'd8,   8'd29};
      vecs[2] = '{8'd2,   8'd25,  8'd3};
      vecs[3] = '{8'd2,   8'd254, 8'd142};
      vecs[4] = '{8'd3,   8'd254, 8'd244};
      vecs[5] = '{8'd253, 8'd254, 8'd255};
      vecs[6] = '{8'd0,   8'd0,   8'd1};
      vecs[7] = '{8'd0,   8'd5,   8'd0};
      vecs[8] = '{8'd7,   8'd255, 8'd1};
      vecs[9] = '{8'd200, 8'd0,   8'd1};

      // Discrete log table built from successive powers of alpha.
      for (int i = 0; i < 256; i++) logt[i] = -1;
      v = 8'h01;
      for (int n = 0; n < 255; n++) begin
         logt[v] = n;
         v = m_mul(v, GF_ALPHA);
      end

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_base   = 8'h00;
      bus.in_exp    = 8'h00;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset_in_ready",  int'(bus.in_ready),  1);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_data",  int'(bus.out_data),  0);
      chk("reset_busy",      int'(bus.busy),      0);

      // First op: latency, in_ready low while busy, ready again after handshake.
      run_op(8'd2, 8'd1, res, lat, ir_low);
      chk("first_result",   int'(res),          2);
      chk("first_latency",  lat,                8);
      chk("first_ir_low",   int'(ir_low),       1);
      chk("first_ir_after", int'(bus.in_ready), 1);
      chk("first_busy_after", int'(bus.busy),   0);

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].b, vecs[i].e, res, lat, ir_low);
         chk($sformatf("vec%0d_b%0d_e%0d", i, vecs[i].b, vecs[i].e), int'(res), int'(vecs[i].r));
         chk($sformatf("vec%0d_latency", i), lat, 8);
      end

      // alpha^n for every n: log of the result must give back n.
      for (int n = 0; n < 255; n++) begin
         run_op(GF_ALPHA, 8'(n), res, lat, ir_low);
         chk($sformatf("alpha_log_n%0d", n), logt[res], n);
      end

      // b^254 is the inverse of every nonzero b.
      for (int b = 1; b < 256; b++) begin
         run_op(8'(b), 8'd254, res, lat, ir_low);
         chk($sformatf("inverse_b%0d", b), int'(m_mul(8'(b), res)), 1);
      end

      for (int i = 0; i < 60; i++) begin
         rb = 8'($urandom);
         re = 8'($urandom);
         if (i < 6) rb = 8'h00;
         run_op(rb, re, res, lat, ir_low);
         chk($sformatf("rand_b%0d_e%0d", rb, re), int'(res), int'(m_pow(rb, re)));
      end

      // Backpressure: hold DONE for 20 cycles while a competing request is offered.
      bus.in_valid = 1'b1;
      bus.in_base  = 8'd2;
      bus.in_exp   = 8'd254;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk("bp_valid_at_8", int'(bus.out_valid), 1);
      bus.in_valid = 1'b1;
      bus.in_base  = 8'd5;
      bus.in_exp   = 8'd3;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (!bus.out_valid || bus.out_data != 8'd142 || bus.in_ready || !bus.busy) stable = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("bp_hold_stable", int'(stable),        1);
      chk("bp_data",        int'(bus.out_data),  142);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_release_ready", int'(bus.in_ready),  1);
      chk("bp_release_valid", int'(bus.out_valid), 0);
      run_op(8'd3, 8'd254, res, lat, ir_low);
      chk("bp_next_result",  int'(res), 244);
      chk("bp_next_latency", lat,       8);

      // Reset during the 4th RUN cycle discards the operation.
      bus.in_valid = 1'b1;
      bus.in_base  = 8'd2;
      bus.in_exp   = 8'd1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("midrun_busy", int'(bus.busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrun_rst_ready", int'(bus.in_ready),  1);
      chk("midrun_rst_valid", int'(bus.out_valid), 0);
      chk("midrun_rst_data",  int'(bus.out_data),  0);
      chk("midrun_rst_busy",  int'(bus.busy),      0);
      stable = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.out_valid || !bus.in_ready) stable = 1'b0;
      end
      chk("midrun_no_output", int'(stable), 1);
      run_op(8'd2, 8'd25, res, lat, ir_low);
      chk("post_rst_result",  int'(res), 3);
      chk("post_rst_latency", lat,       8);

      // Reset and handshake together: reset wins, nothing accepted.
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_base  = 8'd9;
      bus.in_exp   = 8'd9;
      @(posedge clk); #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_vs_hs_ready", int'(bus.in_ready), 1);
      chk("rst_vs_hs_busy",  int'(bus.busy),     0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
